seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Multiplexed 4-digit seven-segment display driver downstream of the memory-mapped output-port bank. It consumes three output-port bytes (16-bit hex value and a control byte) and time-multiplexes them onto a common-anode display. It applies per-digit inter-slot blanking against ghosting and latches inputs once per frame so every displayed frame is coherent.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be ≥ 1.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low.
- value_lo  input  8  digits 1:0 (bits 7:4 → digit 1, bits 3:0 → digit 0, rightmost).
- value_hi  input  8  digits 3:2 (bits 7:4 → digit 3, bits 3:0 → digit 2).
- control  input  8  bit0 display enable; bits 7:4 decimal point for digits 3..0 (bit 4+d → digit d); bits 3:1 reserved, ignored.
- anode_n  output  4  digit select, active-low, bit d → digit d.
- segments  output  7  {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.

## Operation
- Reset: reset is asynchronous, active-low; clock is clock. While reset is low: anode_n=4'hF, segments=7'h7F, dp_n=1, slot counter=0, digit index=0, shadow registers=0.
- Slot counter counts 0..SCAN_DIV-1 and wraps. Digit index advances 0→1→2→3→0 on the wrap.
- Per slot, the FSM has two states: BLANK (counter < BLANK_CYCLES, all outputs off) and DRIVE (counter ≥ BLANK_CYCLES, selected digit driven).
- Frame snapshot: on the edge where the counter wraps with digit index 3, value_lo, value_hi and control load into shadow registers. Display uses only the shadows.
- Because shadows reset to 0 (enable=0), the first frame after reset is dark.
- Enable=0 in shadow: anode_n stays 4'hF for the whole frame.
- Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- During DRIVE, dp_n = ~shadow_control[4+d].

## Timing
- All outputs are registers loaded from next-state values, so they are glitch-free and aligned to internal state:
  - anode_n[d] falls on the edge where the counter becomes BLANK_CYCLES.
  - anode_n[d] rises on the edge where the counter wraps to 0.
- DRIVE lasts SCAN_DIV-BLANK_CYCLES cycles. The frame period is 4·SCAN_DIV cycles.
- Input changes are displayed starting in the digit-0 slot after the next frame boundary. Worst-case latency is 4·SCAN_DIV+1 cycles.
- There are no handshakes; inputs are assumed to be quasi-static register outputs in the same clock domain.
- Reset asserted mid-slot forces outputs off immediately, without waiting for a clock edge. After release, scanning restarts at digit 0 in BLANK.

## Configuration
- LEADING_ZERO_BLANK_EN defined: suppresses leading zeros.
  - Digit 3 is blanked if its nibble is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3..1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit with its dp bit set still asserts its anode, with segments=7'h7F and dp_n=0. Without the dp bit, its anode stays high.
- LEADING_ZERO_BLANK_EN undefined: all four digits are always shown when enabled.

## Structure
- seg7_pkg holds:
  - the 16-entry active-low hex segment table;
  - the SEG_OFF (7'h7F) and ANODE_OFF (4'hF) constants;
  - the digit-index typedef (2-bit);
  - the FSM state enum {BLANK, DRIVE}.
- Sub-module seg7_hex_decode: a combinational nibble → segments lookup, instantiated once on the muxed nibble.

## Test plan
All scenarios use SCAN_DIV=8 and BLANK_CYCLES=2.
- Reset held with inputs nonzero → anode_n=4'hF, segments=7'h7F, dp_n=1. After release, the first 32 cycles are dark.
- value_hi=8'h12, value_lo=8'h34, control=8'h01 → after the first boundary:
  - digit 0: 2 dark cycles, then 6 cycles of anode_n=1110, segments=0011001;
  - then digits 1, 2, 3 show 3, 2, 1 with anode_n=1101, 1011, 0111.
- Change value_lo to 8'hAF mid-frame → the current frame is unchanged. The next digit-0 slot shows F (0001110) and digit 1 shows A (0001000).
- control=8'h20 (enable off, dp1 set) → anode_n stays 4'hF for the full frame.
- With the macro defined, value=16'h0007 and control=8'h21 →
  - digits 3 and 2 are never selected;
  - digit 1 gives anode_n=1101, segments=7F, dp_n=0;
  - digit 0 shows 7 (1111000).
  - Without the macro, digits 3 and 2 show 0 (1000000).
- Assert reset mid-DRIVE of digit 2 → outputs go off within the same cycle. After release, digit 0 is in BLANK and the shadows are cleared.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, all active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  localparam logic [15:0][6:0] SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [1:0] digit_t;

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

endpackage

// File: rtl/seg7_if.sv
// Port-bank to display-driver bundle: value/control bytes in,
// multiplexed anode/segment/dp lines out.
interface seg7_if;

  logic [7:0] value_lo;
  logic [7:0] value_hi;
  logic [7:0] control;
  logic [3:0] anode_n;
  logic [6:0] segments;
  logic       dp_n;

  modport master (
    output value_lo, value_hi, control,
    input  anode_n, segments, dp_n
  );

  modport slave (
    input  value_lo, value_hi, control,
    output anode_n, segments, dp_n
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment lookup.
import seg7_pkg::*;

module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = SEG_TBL[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode driver with per-slot blanking and
// per-frame input snapshot; optional LEADING_ZERO_BLANK_EN hides leading zeros.
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic    clock,
  input logic    reset,
  seg7_if.slave  bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(SCAN_DIV - 1);
  localparam cnt_t BLNK = cnt_t'(BLANK_CYCLES);

  cnt_t       cnt, cnt_nx;
  digit_t     dig, dig_nx;
  state_t     state, state_nx;
  logic       wrap, snap;
  logic [15:0] sh_val;
  logic       sh_en;
  logic [3:0] sh_dp;
  logic [3:0] anode_q, anode_nx;
  logic [6:0] seg_q, seg_nx;
  logic       dp_q, dp_nx;
  logic [3:0] nib;
  logic [6:0] dec;
  logic       hide;
  logic [3:0] sel_n;

  seg7_hex_decode u_dec (
    .nibble   (nib),
    .segments (dec)
  );

  always_comb begin
    wrap   = (cnt == LAST);
    snap   = wrap && (dig == 2'd3);
    cnt_nx = wrap ? '0 : cnt + cnt_t'(1);
    dig_nx = wrap ? dig + 2'd1 : dig;
    unique case (state)
      BLANK:   state_nx = (cnt_nx == BLNK) ? DRIVE : BLANK;
      DRIVE:   state_nx = (cnt_nx == '0) ? BLANK : DRIVE;
      default: state_nx = BLANK;
    endcase
  end

  always_comb begin
    nib   = sh_val[{dig_nx, 2'b00} +: 4];
    sel_n = ~(4'b0001 << dig_nx);
    hide  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    unique case (dig_nx)
      2'd3:    hide = (sh_val[15:12] == 4'h0);
      2'd2:    hide = (sh_val[15:8] == 8'h00);
      2'd1:    hide = (sh_val[15:4] == 12'h000);
      default: hide = 1'b0;
    endcase
`endif
  end

  // Outputs are computed from next state so the registers switch exactly
  // on slot boundaries, never one cycle late.
  always_comb begin
    anode_nx = ANODE_OFF;
    seg_nx   = SEG_OFF;
    dp_nx    = 1'b1;
    if (state_nx == DRIVE && sh_en) begin
      if (!hide) begin
        anode_nx = sel_n;
        seg_nx   = dec;
        dp_nx    = ~sh_dp[dig_nx];
      end else if (sh_dp[dig_nx]) begin
        anode_nx = sel_n;
        dp_nx    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      dig     <= '0;
      state   <= BLANK;
      sh_val  <= '0;
      sh_en   <= 1'b0;
      sh_dp   <= '0;
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      cnt     <= cnt_nx;
      dig     <= dig_nx;
      state   <= state_nx;
      anode_q <= anode_nx;
      seg_q   <= seg_nx;
      dp_q    <= dp_nx;
      if (snap) begin
        sh_val <= {bus.value_hi, bus.value_lo};
        sh_en  <= bus.control[0];
        sh_dp  <= bus.control[7:4];
      end
    end
  end

  assign bus.anode_n  = anode_q;
  assign bus.segments = seg_q;
  assign bus.dp_n     = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2.
// Expected outputs are packed {anode_n, segments, dp_n}.
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seg7_if bus();

  seg7_scan_driver #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] pk(
    input logic [3:0] a,
    input logic [6:0] s,
    input logic       d
  );
    return {a, s, d};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.anode_n, bus.segments, bus.dp_n};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [11:0] got,
    input logic [11:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic slot(input string tag, input logic [11:0] exp);
    for (int i = 0; i < SD; i++) begin
      chk(tag, obs(), (i < BC) ? DARK : exp);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic dark_frame(input string tag);
    for (int i = 0; i < 4; i++) slot(tag, DARK);
  endtask

  initial begin
    bus.value_hi = 8'h12;
    bus.value_lo = 8'h34;
    bus.control  = 8'h01;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_hold", obs(), DARK);
    @(negedge clock);
    reset = 1'b1;

    dark_frame("first_dark");

    slot("f1_d0", pk(4'b1110, 7'h19, 1'b1));
    bus.value_lo = 8'hAF;
    slot("f1_d1", pk(4'b1101, 7'h30, 1'b1));
    slot("f1_d2", pk(4'b1011, 7'h24, 1'b1));
    slot("f1_d3", pk(4'b0111, 7'h79, 1'b1));

    slot("f2_d0", pk(4'b1110, 7'h0E, 1'b1));
    slot("f2_d1", pk(4'b1101, 7'h08, 1'b1));
    bus.control = 8'h20;
    slot("f2_d2", pk(4'b1011, 7'h24, 1'b1));
    slot("f2_d3", pk(4'b0111, 7'h79, 1'b1));

    slot("dis_d0", DARK);
    bus.value_hi = 8'h00;
    bus.value_lo = 8'h07;
    bus.control  = 8'h21;
    slot("dis_d1", DARK);
    slot("dis_d2", DARK);
    slot("dis_d3", DARK);

    slot("lz_d0", pk(4'b1110, 7'h78, 1'b1));
    bus.value_hi = 8'hC5;
    bus.value_lo = 8'hE9;
    bus.control  = 8'hF1;
`ifdef LEADING_ZERO_BLANK_EN
    slot("lz_d1", pk(4'b1101, 7'h7F, 1'b0));
    slot("lz_d2", DARK);
    slot("lz_d3", DARK);
`else
    slot("lz_d1", pk(4'b1101, 7'h40, 1'b0));
    slot("lz_d2", pk(4'b1011, 7'h40, 1'b1));
    slot("lz_d3", pk(4'b0111, 7'h40, 1'b1));
`endif

    slot("dp_d0", pk(4'b1110, 7'h10, 1'b0));
    slot("dp_d1", pk(4'b1101, 7'h06, 1'b0));
    for (int i = 0; i < 5; i++) begin
      chk("dp_d2", obs(),
          (i < BC) ? DARK : pk(4'b1011, 7'h12, 1'b0));
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", obs(), DARK);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    dark_frame("post_rst");
    slot("post_d0", pk(4'b1110, 7'h10, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
